levit_stage_sequencer: RTL

Top-level scheduler for a chain of LeViT attention+MLP stage blocks. It accepts one token word from the host, runs it through N_STAGE stages strictly one at a time, and forwards each stage's output to the next. It drives each stage's enable, shared input bus and four per-head bias buses, and detects stage completion on the stage end flag. Per-stage head biases come from an internal config bank that the host writes before a run.

---
 rtl/levit_stage_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/levit_stage_sequencer.sv
// LeViT stage chain scheduler: runs one token through N_STAGE stages in order; optional STAGE_TIMEOUT_EN adds a watchdog + ERR state.
// Latency: sum over stages of (end cycle + 1 gap cycle); o_done follows the last gap.
// No backpressure: start/cfg writes are dropped while busy, stage end flags are the only handshake.
module levit_stage_sequencer #(
    parameter int N_STAGE   = 3,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          cfg_we,
    input  logic [$clog2(4*N_STAGE)-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]             cfg_wdata,
    output logic [N_STAGE-1:0]            stage_en,
    output logic [DATA_W-1:0]             stage_in,
    output logic [DATA_W-1:0]             stage_bias_1,
    output logic [DATA_W-1:0]             stage_bias_2,
    output logic [DATA_W-1:0]             stage_bias_3,
    output logic [DATA_W-1:0]             stage_bias_4,
    input  logic [N_STAGE-1:0]            stage_end,
    input  logic [N_STAGE*DATA_W-1:0]     stage_out,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_err
);

    localparam int BANK = 4 * N_STAGE;
    localparam int AW   = $clog2(BANK);
    localparam int IW   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        GAP  = 3'd2,
`ifdef STAGE_TIMEOUT_EN
        ERR  = 3'd4,
`endif
        DONE = 3'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] bank [BANK];
    logic [AW-1:0]     bias_base;
    logic              end_hit;
    logic              last_stage;
    logic              accept;
`ifdef STAGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog;
`endif

    assign end_hit    = (state == RUN) && stage_end[idx];
    assign last_stage = (idx == IW'(N_STAGE - 1));
    assign bias_base  = AW'({idx, 2'b00});
    assign o_busy     = (state == RUN) || (state == GAP) || (state == DONE);
    assign o_done     = (state == DONE);
    assign accept     = start && !o_busy;
`ifdef STAGE_TIMEOUT_EN
    assign o_err      = (state == ERR);
`else
    assign o_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stage_en     = '0;
        stage_in     = '0;
        stage_bias_1 = '0;
        stage_bias_2 = '0;
        stage_bias_3 = '0;
        stage_bias_4 = '0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                stage_en     = N_STAGE'(1) << idx;
                stage_in     = data_reg;
                stage_bias_1 = bank[bias_base];
                stage_bias_2 = bank[bias_base + AW'(1)];
                stage_bias_3 = bank[bias_base + AW'(2)];
                stage_bias_4 = bank[bias_base + AW'(3)];
                if (end_hit) state_nxt = GAP;
`ifdef STAGE_TIMEOUT_EN
                else if (wdog == '1) state_nxt = ERR;
`endif
            end
            // One idle cycle lets the finished stage drop its end flag.
            GAP:  state_nxt = last_stage ? DONE : RUN;
            DONE: state_nxt = IDLE;
`ifdef STAGE_TIMEOUT_EN
            ERR:  if (start) state_nxt = RUN;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            data_reg <= '0;
            o_data   <= '0;
            for (int i = 0; i < BANK; i++) bank[i] <= '0;
        end else begin
            if (cfg_we && !o_busy && (int'(cfg_addr) < BANK))
                bank[cfg_addr] <= cfg_wdata;
            if (accept) begin
                data_reg <= i_data;
                idx      <= '0;
            end
            if (end_hit)
                data_reg <= stage_out[int'(idx)*DATA_W +: DATA_W];
            if (state == GAP) begin
                if (last_stage) o_data <= data_reg;
                else            idx    <= idx + 1'b1;
            end
        end
    end

`ifdef STAGE_TIMEOUT_EN
    // Counts RUN cycles without an end flag; all-ones on a further miss means 2^TIMEOUT_W cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog <= '0;
        else if (state_nxt == RUN && state != RUN)
            wdog <= '0;
        else if (state == RUN && !end_hit)
            wdog <= wdog + 1'b1;
    end
`endif

endmodule
